// File: rtl/or_and_result_serializer_if.sv
// Valid/ready input port and serial status bundle for the OR/AND result serializer.
// The master modport is the producer/observer side. The slave modport is the serializer.
interface or_and_result_serializer_if #(
  parameter int DEPTH = 4
) ();
  logic                     ena;
  logic                     in_valid;
  logic [7:0]               in_data;
  logic                     in_tag;
  logic                     in_ready;
  logic                     tx;
  logic                     busy;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     overflow;

  modport master (
    output ena, in_valid, in_data, in_tag,
    input  in_ready, tx, busy, fifo_count, overflow
  );

  modport slave (
    input  ena, in_valid, in_data, in_tag,
    output in_ready, tx, busy, fifo_count, overflow
  );
endinterface

// File: rtl/or_and_result_serializer.sv
// Buffers tagged OR/AND results in a small FIFO and sends each one on a single-wire frame.
// Frame layout: start(0), data LSB first, tag, stop(1). Each bit lasts CLKS_PER_BIT clocks.
module or_and_result_serializer #(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input logic                       clk,
  input logic                       rst,
  or_and_result_serializer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CLK   = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_TAG, S_STOP} state_t;

  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  state_t        r_state, w_state_next;
  logic [8:0]    r_shift, w_shift_next;
  logic [2:0]    r_bit_idx, w_bit_idx_next;
  logic [CW-1:0] r_clk_cnt, w_clk_cnt_next;
  logic          r_tx, w_tx_next;

  logic w_full, w_empty, w_push, w_pop, w_bit_end;

  assign w_full    = (r_count == FULL_COUNT);
  assign w_empty   = (r_count == '0);
  assign w_push    = bus.ena & bus.in_valid & ~w_full;
  assign w_pop     = bus.ena & (r_state == S_IDLE) & ~w_empty;
  assign w_bit_end = (r_clk_cnt == LAST_CLK);

  // NOTE: the FIFO storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.in_tag, bus.in_data};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (bus.ena & bus.in_valid & w_full) r_overflow <= 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    w_clk_cnt_next = r_clk_cnt;
    if (bus.ena) begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            w_state_next   = S_START;
            w_shift_next   = r_mem[r_rd_ptr];
            w_clk_cnt_next = '0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            w_state_next   = S_DATA;
            w_bit_idx_next = '0;
            w_clk_cnt_next = '0;
          end else begin
            w_clk_cnt_next = r_clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            w_shift_next   = {1'b0, r_shift[8:1]};
            w_clk_cnt_next = '0;
            if (r_bit_idx == 3'd7) w_state_next = S_TAG;
            else                   w_bit_idx_next = r_bit_idx + 1'b1;
          end else begin
            w_clk_cnt_next = r_clk_cnt + 1'b1;
          end
        end
        S_TAG: begin
          if (w_bit_end) begin
            w_state_next   = S_STOP;
            w_clk_cnt_next = '0;
          end else begin
            w_clk_cnt_next = r_clk_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            w_state_next   = S_IDLE;
            w_clk_cnt_next = '0;
          end else begin
            w_clk_cnt_next = r_clk_cnt + 1'b1;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // After eight data shifts the tag sits in shift[0], so DATA and TAG share one tx source.
  always_comb begin
    unique case (w_state_next)
      S_START:        w_tx_next = 1'b0;
      S_DATA, S_TAG:  w_tx_next = w_shift_next[0];
      default:        w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_clk_cnt <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_clk_cnt <= w_clk_cnt_next;
      r_tx      <= w_tx_next;
    end
  end

  assign bus.in_ready   = bus.ena & ~w_full;
  assign bus.tx         = r_tx;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.fifo_count = r_count;
  assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_or_and_result_serializer.sv
// Self-checking bench: per-cycle queue-based reference model, a frame vector table, and
// hand-written sequences for full, simultaneous push/pop, reset and enable-gating cases.
module tb_or_and_result_serializer;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  or_and_result_serializer_if #(.DEPTH(DEPTH)) bus ();

  or_and_result_serializer #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: queue of words waiting, queue of tx levels still to be sent.
  logic [8:0] m_q [$];
  bit         m_fr [$];
  bit         m_ovf;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_fr.delete();
    m_ovf = 1'b0;
  endfunction

  function automatic void model_load(input logic [8:0] w);
    bit b;
    for (int p = 0; p < 11; p++) begin
      if (p == 0)      b = 1'b0;
      else if (p <= 9) b = w[p-1];
      else             b = 1'b1;
      repeat (CPB) m_fr.push_back(b);
    end
  endfunction

  function automatic void model_step(input logic e, input logic v, input logic [7:0] d,
                                     input logic t);
    bit do_pop, do_push;
    logic [8:0] w;
    if (!e) return;
    do_pop  = (m_fr.size() == 0) && (m_q.size() > 0);
    do_push = v && (m_q.size() < DEPTH);
    if (v && !do_push) m_ovf = 1'b1;
    if (m_fr.size() != 0) void'(m_fr.pop_front());
    if (do_pop) begin
      w = m_q.pop_front();
      model_load(w);
    end
    if (do_push) m_q.push_back({t, d});
  endfunction

  // One clock: drive at the falling edge, compare just after, advance the model for the next rise.
  task automatic step(input logic r, input logic e, input logic v, input logic [7:0] d,
                      input logic t);
    @(negedge clk);
    rst = r; bus.ena = e; bus.in_valid = v; bus.in_data = d; bus.in_tag = t;
    #1;
    if (r) begin
      check("rst_tx",       16'(bus.tx),         16'd1);
      check("rst_busy",     16'(bus.busy),       16'd0);
      check("rst_count",    16'(bus.fifo_count), 16'd0);
      check("rst_overflow", 16'(bus.overflow),   16'd0);
      model_reset();
    end else begin
      check("tx",         16'(bus.tx),         16'((m_fr.size() != 0) ? m_fr[0] : 1'b1));
      check("busy",       16'(bus.busy),       16'(m_fr.size() != 0));
      check("fifo_count", 16'(bus.fifo_count), 16'(m_q.size()));
      check("in_ready",   16'(bus.in_ready),   16'(e && (m_q.size() < DEPTH)));
      check("overflow",   16'(bus.overflow),   16'(m_ovf));
      model_step(e, v, d, t);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic push(input logic [7:0] d, input logic t);
    step(1'b0, 1'b1, 1'b1, d, t);
  endtask

  task automatic drain();
    int budget = 2000;
    while ((m_q.size() != 0 || m_fr.size() != 0) && budget > 0) begin
      idle(1);
      budget--;
    end
    check("drain_timeout", 16'(budget > 0), 16'd1);
    idle(2);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        tag;
    logic [10:0] periods;  // bit i = expected tx level during bit period i
  } frame_vec_t;

  frame_vec_t vecs [4];

  initial begin
    vecs[0] = '{data: 8'h14, tag: 1'b0, periods: 11'b100_0010_1000};
    vecs[1] = '{data: 8'h9E, tag: 1'b1, periods: 11'b111_0011_1100};
    vecs[2] = '{data: 8'hFF, tag: 1'b1, periods: 11'b111_1111_1110};
    vecs[3] = '{data: 8'h00, tag: 1'b0, periods: 11'b100_0000_0000};

    bus.ena = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_tag = 1'b0;
    model_reset();
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    idle(3);

    // Single frames with exact bit-period waveforms.
    foreach (vecs[k]) begin
      push(vecs[k].data, vecs[k].tag);
      idle(1);
      check("start_delay_tx", 16'(bus.tx), 16'd1);
      for (int p = 0; p < 11; p++) begin
        for (int c = 0; c < CPB; c++) begin
          idle(1);
          check("frame_bit", 16'(bus.tx), 16'(vecs[k].periods[p]));
          check("frame_busy", 16'(bus.busy), 16'd1);
        end
      end
      idle(1);
      check("post_frame_busy", 16'(bus.busy), 16'd0);
      check("post_frame_tx", 16'(bus.tx), 16'd1);
      idle(2);
    end

    // Fill: five back-to-back pushes, the sixth is dropped.
    for (int i = 1; i <= 5; i++) push(8'(i), 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h06, 1'b1);
    check("full_count", 16'(bus.fifo_count), 16'd4);
    check("full_in_ready", 16'(bus.in_ready), 16'd0);
    idle(1);
    check("overflow_set", 16'(bus.overflow), 16'd1);
    drain();

    // Push on the IDLE pop cycle with one word queued.
    push(8'hA5, 1'b1);
    push(8'h5A, 1'b0);
    idle(1);
    check("simul_count", 16'(bus.fifo_count), 16'd1);
    drain();

    // Reset mid-frame with another word still queued.
    push(8'h33, 1'b0);
    push(8'h44, 1'b1);
    idle(15);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    idle(12);
    check("after_rst_count", 16'(bus.fifo_count), 16'd0);

    // Freeze for seven cycles inside data bit 3 (0xC8 has bit3=1, bit4=0).
    push(8'hC8, 1'b1);
    idle(19);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'hEE, 1'b1);
      check("frozen_tx", 16'(bus.tx), 16'd1);
      check("frozen_count", 16'(bus.fifo_count), 16'd0);
    end
    idle(1);
    check("resume_bit3_a", 16'(bus.tx), 16'd1);
    idle(1);
    check("resume_bit3_b", 16'(bus.tx), 16'd1);
    idle(1);
    check("resume_bit4", 16'(bus.tx), 16'd0);
    drain();
    check("frozen_no_overflow", 16'(bus.overflow), 16'd0);

    // Random traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      step(1'b0, ($urandom % 10) != 0, ($urandom % 3) == 0, 8'($urandom), 1'($urandom));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
